// File: rtl/morra_pkg.sv
// rtl/morra_pkg.sv - shared move/result/state types and the scoring rule for the morra referee
package morra_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ROCK     = 2'b01,
    PAPER    = 2'b10,
    SCISSORS = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    NO_RES = 2'b00,
    P1     = 2'b01,
    P2     = 2'b10,
    DRAW   = 2'b11
  } res_t;

  typedef enum logic {
    PLAY = 1'b0,
    DONE = 1'b1
  } fsm_t;

  function automatic logic beats(input move_t a, input move_t b);
    return ((a == ROCK) && (b == SCISSORS)) ||
           ((a == SCISSORS) && (b == PAPER)) ||
           ((a == PAPER) && (b == ROCK));
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// rtl/morra_round_judge.sv - combinational validity and outcome of one move pair
// A lock of NONE never blocks a move, so the top can tie the locks off when unused.
module morra_round_judge
  import morra_pkg::*;
(
  input  move_t p1_i,
  input  move_t p2_i,
  input  move_t lock1_i,
  input  move_t lock2_i,
  output logic  valid_o,
  output res_t  res_o
);

  always_comb begin
    valid_o = (p1_i != NONE) && (p2_i != NONE) &&
              (p1_i != lock1_i) && (p2_i != lock2_i);
    res_o   = NO_RES;
    if (valid_o) begin
      if (p1_i == p2_i)          res_o = DRAW;
      else if (beats(p1_i, p2_i)) res_o = P1;
      else                        res_o = P2;
    end
  end

endmodule

// File: rtl/morra_match_referee.sv
// rtl/morra_match_referee.sv - two-player morra match referee: FSM, counters, lead and config
// Optional winner move lock is enabled by defining MORRA_MOVE_LOCK_EN.
module morra_match_referee
  import morra_pkg::*;
#(
  parameter int MIN_ROUNDS = 4,
  parameter int WIN_LEAD   = 2,
  parameter int LEAD_SAT   = 3,
  parameter int CNT_W      = 5,
  localparam int LW        = $clog2(LEAD_SAT) + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           p1_move_i,
  input  logic [1:0]           p2_move_i,
  output logic [1:0]           round_res_o,
  output logic [1:0]           match_res_o,
  output logic                 match_done_o,
  output logic [CNT_W-1:0]     round_cnt_o,
  output logic signed [LW-1:0] lead_o
);

  localparam logic signed [LW-1:0] SAT_P  = LW'(LEAD_SAT);
  localparam logic signed [LW-1:0] SAT_N  = -SAT_P;
  localparam logic signed [LW-1:0] WIN_S  = LW'(WIN_LEAD);
  localparam logic signed [LW-1:0] ONE_S  = LW'(1);
  localparam logic [CNT_W-1:0]     MIN_C  = CNT_W'(MIN_ROUNDS);
  localparam logic [CNT_W-1:0]     ONE_C  = CNT_W'(1);

  fsm_t                 state_q;
  res_t                 round_res_q, match_res_q, mres_d;
  logic                 done_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d, max_q;
  logic signed [LW-1:0] lead_q, lead_d, lead_mag;
  logic                 decide;

  move_t p1_mv, p2_mv, lock1, lock2;
  logic  valid;
  res_t  res;

  assign p1_mv = move_t'(p1_move_i);
  assign p2_mv = move_t'(p2_move_i);

  morra_round_judge u_judge (
    .p1_i    (p1_mv),
    .p2_i    (p2_mv),
    .lock1_i (lock1),
    .lock2_i (lock2),
    .valid_o (valid),
    .res_o   (res)
  );

`ifdef MORRA_MOVE_LOCK_EN
  move_t lock1_q, lock2_q;

  // Every valid round rewrites both locks; only the round winner keeps its move locked.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock1_q <= NONE;
      lock2_q <= NONE;
    end else if (state_q == PLAY && valid) begin
      lock1_q <= (res == P1) ? p1_mv : NONE;
      lock2_q <= (res == P2) ? p2_mv : NONE;
    end
  end

  assign lock1 = lock1_q;
  assign lock2 = lock2_q;
`else
  assign lock1 = NONE;
  assign lock2 = NONE;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    lead_d = lead_q;
    if (valid) begin
      cnt_d = cnt_q + ONE_C;
      if (res == P1 && lead_q != SAT_P) lead_d = lead_q + ONE_S;
      if (res == P2 && lead_q != SAT_N) lead_d = lead_q - ONE_S;
    end
    lead_mag = lead_d[LW-1] ? -lead_d : lead_d;
    // Lead rule is checked on the saturated lead; the round cap catches everything else.
    decide   = valid && (((cnt_d >= MIN_C) && (lead_mag >= WIN_S)) || (cnt_d == max_q));
    if (lead_d == '0)      mres_d = DRAW;
    else if (lead_d[LW-1]) mres_d = P2;
    else                   mres_d = P1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLAY;
      round_res_q <= NO_RES;
      match_res_q <= NO_RES;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      lead_q      <= '0;
      max_q       <= MIN_C + CNT_W'({p1_move_i, p2_move_i});
    end else begin
      case (state_q)
        PLAY: begin
          round_res_q <= res;
          cnt_q       <= cnt_d;
          lead_q      <= lead_d;
          if (decide) begin
            state_q     <= DONE;
            match_res_q <= mres_d;
            done_q      <= 1'b1;
          end
        end
        DONE: round_res_q <= NO_RES;
        default: state_q <= PLAY;
      endcase
    end
  end

  assign round_res_o  = round_res_q;
  assign match_res_o  = match_res_q;
  assign match_done_o = done_q;
  assign round_cnt_o  = cnt_q;
  assign lead_o       = lead_q;

endmodule

// File: tb/tb_morra_match_referee.sv
// tb/tb_morra_match_referee.sv - self-checking bench for morra_match_referee
// Rule-level match model compared every cycle, plus literal expectations per scenario.
module tb_morra_match_referee;

  localparam int MIN_ROUNDS = 4;
  localparam int WIN_LEAD   = 2;
  localparam int LEAD_SAT   = 3;
  localparam int CNT_W      = 5;

  logic                clk   = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          p1    = 2'b00;
  logic [1:0]          p2    = 2'b00;
  logic [1:0]          round_res, match_res;
  logic                match_done;
  logic [CNT_W-1:0]    round_cnt;
  logic signed [3:0]   lead;

  int checks   = 0;
  int failures = 0;

  int e_round = 0, e_mres = 0, e_done = 0, e_cnt = 0, e_lead = 0, e_max = 0;
  int l1 = 0, l2 = 0;

  always #5 clk = ~clk;

  morra_match_referee #(
    .MIN_ROUNDS (MIN_ROUNDS),
    .WIN_LEAD   (WIN_LEAD),
    .LEAD_SAT   (LEAD_SAT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .p1_move_i    (p1),
    .p2_move_i    (p2),
    .round_res_o  (round_res),
    .match_res_o  (match_res),
    .match_done_o (match_done),
    .round_cnt_o  (round_cnt),
    .lead_o       (lead)
  );

  // Moves 1,2,3 = rock,paper,scissors: a beats b exactly when (a-b) mod 3 == 1.
  always @(posedge clk) begin : model
    automatic int a, b, w, nl, nc;
    automatic bit v;
    a = int'(p1);
    b = int'(p2);
    if (reset) begin
      e_round <= 0; e_mres <= 0; e_done <= 0; e_cnt <= 0; e_lead <= 0;
      e_max   <= MIN_ROUNDS + a * 4 + b;
      l1      <= 0; l2 <= 0;
    end else if (e_done != 0) begin
      e_round <= 0;
    end else begin
      v = (a != 0) && (b != 0);
`ifdef MORRA_MOVE_LOCK_EN
      v = v && (a != l1) && (b != l2);
`endif
      if (!v) begin
        e_round <= 0;
      end else begin
        w  = (a == b) ? 3 : (((a - b + 3) % 3 == 1) ? 1 : 2);
        nl = e_lead + ((w == 1) ? 1 : 0) - ((w == 2) ? 1 : 0);
        if (nl > LEAD_SAT)  nl = LEAD_SAT;
        if (nl < -LEAD_SAT) nl = -LEAD_SAT;
        nc = e_cnt + 1;
        e_round <= w;
        e_cnt   <= nc;
        e_lead  <= nl;
        if ((nc >= MIN_ROUNDS && (nl >= WIN_LEAD || -nl >= WIN_LEAD)) || nc == e_max) begin
          e_done <= 1;
          e_mres <= (nl > 0) ? 1 : ((nl < 0) ? 2 : 3);
        end
        l1 <= (w == 1) ? a : 0;
        l2 <= (w == 2) ? b : 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check("round_res",  int'(round_res),  e_round);
    check("match_res",  int'(match_res),  e_mres);
    check("match_done", int'(match_done), e_done);
    check("round_cnt",  int'(round_cnt),  e_cnt);
    check("lead",       int'(lead),       e_lead);
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic r);
    p1    = a;
    p2    = b;
    reset = r;
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  initial begin
    // Scenario 1: max=6, P1 wins four in a row, lead saturates at 3
    step(2'd0, 2'd2, 1'b1);
    check("t1_reset_cnt", int'(round_cnt), 0);
    step(2'd1, 2'd3, 1'b0);
`ifndef MORRA_MOVE_LOCK_EN
    check("t1_lead_r1", int'(lead), 1);
`endif
    step(2'd1, 2'd3, 1'b0);
`ifndef MORRA_MOVE_LOCK_EN
    check("t1_lead_r2", int'(lead), 2);
`endif
    step(2'd2, 2'd1, 1'b0);
`ifndef MORRA_MOVE_LOCK_EN
    check("t1_lead_r3", int'(lead), 3);
    check("t1_done_r3", int'(match_done), 0);
`endif
    step(2'd3, 2'd2, 1'b0);
`ifndef MORRA_MOVE_LOCK_EN
    check("t1_done_r4", int'(match_done), 1);
    check("t1_mres_r4", int'(match_res), 1);
    check("t1_lead_sat", int'(lead), 3);
    check("t1_cnt_r4", int'(round_cnt), 4);
`endif
    // Scenario 5: frozen in DONE, then a clean restart
    step(2'd1, 2'd3, 1'b0);
    step(2'd2, 2'd1, 1'b0);
`ifndef MORRA_MOVE_LOCK_EN
    check("t5_round_res_done", int'(round_res), 0);
    check("t5_cnt_frozen", int'(round_cnt), 4);
`endif
    step(2'd0, 2'd0, 1'b1);
    check("t5_reset_done", int'(match_done), 0);
    check("t5_reset_mres", int'(match_res), 0);
    check("t5_reset_lead", int'(lead), 0);
    // Scenario 3: max=4, alternating winners end level on the cap
    step(2'd1, 2'd3, 1'b0);
    step(2'd3, 2'd1, 1'b0);
    step(2'd2, 2'd1, 1'b0);
    step(2'd1, 2'd2, 1'b0);
`ifndef MORRA_MOVE_LOCK_EN
    check("t3_lead", int'(lead), 0);
    check("t3_mres_draw", int'(match_res), 3);
    check("t3_done", int'(match_done), 1);
`endif
    // Scenario 4 and lock scenario 2
    step(2'd0, 2'd2, 1'b1);
    step(2'd2, 2'd1, 1'b0);
    check("t4_first_cnt", int'(round_cnt), 1);
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 2'd1, 1'b0);
      check("t4_idle_res", int'(round_res), 0);
      check("t4_idle_cnt", int'(round_cnt), 1);
      check("t4_idle_lead", int'(lead), 1);
    end
    step(2'd2, 2'd3, 1'b0);
`ifdef MORRA_MOVE_LOCK_EN
    check("t4_lock_kept", int'(round_res), 0);
`endif
    step(2'd1, 2'd3, 1'b0);
    step(2'd1, 2'd2, 1'b0);
`ifdef MORRA_MOVE_LOCK_EN
    check("t2_repeat_res", int'(round_res), 0);
    check("t2_repeat_cnt", int'(round_cnt), 2);
`endif
    step(2'd3, 2'd3, 1'b0);
`ifdef MORRA_MOVE_LOCK_EN
    check("t2_loser_repeat", int'(round_res), 3);
`endif
    // Scenario 6: abort mid-match, new cap 4+6=10 reached by draws
    step(2'd0, 2'd1, 1'b1);
    step(2'd1, 2'd3, 1'b0);
    step(2'd1, 2'd3, 1'b0);
    step(2'd1, 2'd2, 1'b1);
    check("t6_abort_cnt", int'(round_cnt), 0);
    check("t6_abort_res", int'(round_res), 0);
    for (int i = 1; i <= 10; i++) begin
      step(2'd1, 2'd1, 1'b0);
      check("t6_draw_cnt", int'(round_cnt), i);
    end
    check("t6_cap_done", int'(match_done), 1);
    check("t6_cap_mres", int'(match_res), 3);
    step(2'd1, 2'd3, 1'b0);
    check("t6_no_overrun", int'(round_cnt), 10);
    // Mixed traffic with occasional resets, checked against the model only
    for (int i = 0; i < 200; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
